// File: rtl/decode12_seq.sv
// Sequencer that streams K polynomials of ByteDecode_12 input bytes through one
// decode12 instance and writes each decoded coefficient pair to coefficient RAM.
module decode12_seq #(
    parameter int unsigned KMAX = 4,
    parameter int unsigned Q    = 3329,
    parameter int unsigned IDXW = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [2:0]      k_num,
    input  logic            s_valid,
    input  logic [7:0]      s_data,
    output logic            s_ready,
    output logic            dec_reset,
    output logic            dec_set,
    output logic            dec_readin,
    output logic [7:0]      dec_din,
    output logic [IDXW-1:0] dec_in_index,
    input  logic [15:0]     dec_dout_1,
    input  logic [15:0]     dec_dout_2,
    input  logic [IDXW-1:0] dec_out_index,
    output logic            wr_en,
    output logic [8:0]      wr_addr,
    output logic [23:0]     wr_data,
    output logic            busy,
    output logic            done,
    output logic            mod_err
);

    localparam int unsigned BCW    = 11;  // up to 384*4 = 1536 bytes
    localparam int unsigned PCW    = 10;  // up to 128*4 = 512 pairs
    localparam int unsigned WDW    = 4;
    localparam logic [WDW-1:0] WD_LAST = WDW'(15);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
        S_FEED,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t          state, next_state;
    logic [2:0]      k_q, k_d;
    logic [BCW-1:0]  byte_cnt, byte_cnt_d;
    logic [PCW-1:0]  pair_cnt, pair_cnt_d;
    logic [IDXW-1:0] last_oi, last_oi_d;
    logic [WDW-1:0]  wdog, wdog_d;

    logic            s_ready_d, dec_reset_d, dec_set_d, dec_readin_d;
    logic [7:0]      dec_din_d;
    logic [IDXW-1:0] dec_in_index_d;
    logic            wr_en_d;
    logic [8:0]      wr_addr_d;
    logic [23:0]     wr_data_d;
    logic            busy_d, done_d, mod_err_d;

    logic [2:0]      k_eff_c;
    logic [BCW-1:0]  total_bytes_c;
    logic [PCW-1:0]  total_pairs_c;
    logic            accept_c;
    logic            pair_new_c;

    assign k_eff_c       = (k_num == 3'd0 || k_num > 3'(KMAX)) ? 3'd1 : k_num;
    assign total_bytes_c = BCW'(384) * BCW'(k_q);
    assign total_pairs_c = PCW'(128) * PCW'(k_q);
    assign accept_c      = s_valid && s_ready;
    assign pair_new_c    = (state == S_FEED || state == S_DRAIN) && (dec_out_index != last_oi);

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            k_q          <= '0;
            byte_cnt     <= '0;
            pair_cnt     <= '0;
            last_oi      <= '0;
            wdog         <= '0;
            s_ready      <= 1'b0;
            dec_reset    <= 1'b0;
            dec_set      <= 1'b0;
            dec_readin   <= 1'b0;
            dec_din      <= '0;
            dec_in_index <= '0;
            wr_en        <= 1'b0;
            wr_addr      <= '0;
            wr_data      <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            mod_err      <= 1'b0;
        end else begin
            state        <= next_state;
            k_q          <= k_d;
            byte_cnt     <= byte_cnt_d;
            pair_cnt     <= pair_cnt_d;
            last_oi      <= last_oi_d;
            wdog         <= wdog_d;
            s_ready      <= s_ready_d;
            dec_reset    <= dec_reset_d;
            dec_set      <= dec_set_d;
            dec_readin   <= dec_readin_d;
            dec_din      <= dec_din_d;
            dec_in_index <= dec_in_index_d;
            wr_en        <= wr_en_d;
            wr_addr      <= wr_addr_d;
            wr_data      <= wr_data_d;
            busy         <= busy_d;
            done         <= done_d;
            mod_err      <= mod_err_d;
        end
    end

    // Next-state, counters and next output values
    always_comb begin
        next_state     = state;
        k_d            = k_q;
        byte_cnt_d     = byte_cnt;
        pair_cnt_d     = pair_cnt;
        last_oi_d      = last_oi;
        wdog_d         = wdog;
        dec_readin_d   = 1'b0;
        dec_din_d      = dec_din;
        dec_in_index_d = dec_in_index;
        wr_en_d        = 1'b0;
        wr_addr_d      = wr_addr;
        wr_data_d      = wr_data;
        mod_err_d      = mod_err;

        case (state)
            S_IDLE: begin
                if (start) begin
                    next_state = S_CLR;
                    k_d        = k_eff_c;
                    mod_err_d  = 1'b0;
                    byte_cnt_d = '0;
                    pair_cnt_d = '0;
                    last_oi_d  = '0;
                    wdog_d     = '0;
                end
            end
            S_CLR: next_state = S_FEED;
            S_FEED: begin
                if (accept_c) begin
                    dec_readin_d   = 1'b1;
                    dec_din_d      = s_data;
                    dec_in_index_d = IDXW'(byte_cnt);
                    byte_cnt_d     = byte_cnt + BCW'(1);
                    if (byte_cnt_d == total_bytes_c) begin
                        next_state = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (pair_cnt == total_pairs_c) begin
                    next_state = S_DONE;
                end else if (!pair_new_c && wdog == WD_LAST) begin
                    // decoder stalled without delivering every pair
                    next_state = S_DONE;
                    mod_err_d  = 1'b1;
                end else begin
                    wdog_d = pair_new_c ? '0 : wdog + WDW'(1);
                end
            end
            S_DONE: next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase

        // Capture a freshly decoded pair and range-check it
        if (pair_new_c) begin
            last_oi_d = dec_out_index;
            if (pair_cnt < total_pairs_c) begin
                wr_en_d    = 1'b1;
                wr_addr_d  = pair_cnt[8:0];
                wr_data_d  = {dec_dout_2[11:0], dec_dout_1[11:0]};
                pair_cnt_d = pair_cnt + PCW'(1);
            end
            if (dec_out_index - last_oi != IDXW'(1)) begin
                mod_err_d = 1'b1;
            end
            if (dec_dout_1[11:0] >= 12'(Q) || dec_dout_2[11:0] >= 12'(Q) ||
                dec_dout_1[15:12] != 4'd0 || dec_dout_2[15:12] != 4'd0) begin
                mod_err_d = 1'b1;
            end
        end

        s_ready_d   = (next_state == S_FEED) && (byte_cnt_d < total_bytes_c);
        dec_reset_d = (next_state == S_CLR);
        dec_set_d   = (next_state == S_FEED) || (next_state == S_DRAIN);
        busy_d      = (next_state == S_CLR) || (next_state == S_FEED) || (next_state == S_DRAIN);
        done_d      = (next_state == S_DONE);
    end

endmodule

// File: tb/tb_decode12_seq.sv
// Randomized bench for decode12_seq with a behavioural decode12 stub and a
// byte-stream reference model of ByteDecode_12 and the modulus check.
module tb_decode12_seq;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  k_num = 3'd1;
    logic        s_valid = 1'b0;
    logic [7:0]  s_data = 8'd0;
    logic        s_ready;
    logic        dec_reset, dec_set, dec_readin;
    logic [7:0]  dec_din;
    logic [15:0] dec_in_index;
    logic [15:0] dec_dout_1 = '0, dec_dout_2 = '0, dec_out_index = '0;
    logic        wr_en;
    logic [8:0]  wr_addr;
    logic [23:0] wr_data;
    logic        busy, done, mod_err;

    always #5 clk = ~clk;

    decode12_seq dut (
        .clk(clk), .reset(reset), .start(start), .k_num(k_num),
        .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .dec_reset(dec_reset), .dec_set(dec_set), .dec_readin(dec_readin),
        .dec_din(dec_din), .dec_in_index(dec_in_index),
        .dec_dout_1(dec_dout_1), .dec_dout_2(dec_dout_2), .dec_out_index(dec_out_index),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .busy(busy), .done(done), .mod_err(mod_err)
    );

    int n_checks = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, want, $time);
        end
    endtask

    // decode12 stub: three bytes in, one coefficient pair out; can drop one pair
    int         skip_pair = -1;
    int         stub_pc = 0;
    bit         stub_pend = 1'b0;
    logic [7:0] sb0 = '0, sb1 = '0;

    always @(posedge clk) begin
        if (dec_reset) begin
            dec_out_index <= '0;
            stub_pc       <= 0;
            stub_pend     <= 1'b0;
        end else if (dec_set && dec_readin) begin
            case (dec_in_index % 16'd3)
                16'd0: sb0 <= dec_din;
                16'd1: sb1 <= dec_din;
                default: begin
                    stub_pc <= stub_pc + 1;
                    if (stub_pc == skip_pair) begin
                        stub_pend <= 1'b1;
                    end else begin
                        dec_dout_1    <= {4'h0, sb1[3:0], sb0};
                        dec_dout_2    <= {4'h0, dec_din, sb1[7:4]};
                        dec_out_index <= dec_out_index + 16'(1 + int'(stub_pend));
                        stub_pend     <= 1'b0;
                    end
                end
            endcase
        end
    end

    // Stimulus bytes and reference model
    logic [7:0] byte_q[$];
    int         exp_q[$];
    bit         exp_err;

    task automatic gen_bytes(input int n, input int mode);
        int c1, c2;
        byte_q.delete();
        for (int p = 0; p < n / 3; p++) begin
            if (mode == 0) begin
                byte_q.push_back(8'h01); byte_q.push_back(8'h23); byte_q.push_back(8'h45);
            end else begin
                c1 = int'($urandom_range(3328));
                c2 = int'($urandom_range(3328));
                if (mode == 2 && p == 5) begin
                    c1 = 4095;
                    c2 = 4095;
                end
                byte_q.push_back(8'(c1 % 256));
                byte_q.push_back(8'(c1 / 256 + 16 * (c2 % 16)));
                byte_q.push_back(8'(c2 / 16));
            end
        end
    endtask

    task automatic build_model(input int np, input int skip);
        int c1, c2;
        exp_q.delete();
        exp_err = (skip >= 0);
        for (int p = 0; p < np; p++) begin
            c1 = int'(byte_q[3*p]) + 256 * (int'(byte_q[3*p+1]) % 16);
            c2 = int'(byte_q[3*p+1]) / 16 + 16 * int'(byte_q[3*p+2]);
            if (c1 >= 3329 || c2 >= 3329) exp_err = 1'b1;
            if (p != skip) exp_q.push_back(c2 * 4096 + c1);
        end
    endtask

    // Output monitor, sampled on the falling edge
    int waddr_q[$];
    int wdata_q[$];
    int done_cnt = 0;
    int exp_idx = 0;
    int idx_err = 0;

    always @(negedge clk) begin
        if (wr_en) begin
            waddr_q.push_back(int'(wr_addr));
            wdata_q.push_back(int'(wr_data));
        end
        if (done) done_cnt++;
        if (dec_readin) begin
            if (exp_idx >= byte_q.size() || int'(dec_in_index) != exp_idx || dec_din != byte_q[exp_idx])
                idx_err++;
            exp_idx++;
        end
    end

    task automatic clear_monitor();
        waddr_q.delete();
        wdata_q.delete();
        done_cnt = 0;
        exp_idx = 0;
        idx_err = 0;
    endtask

    // Source: s_valid asserted with probability pct; returns accept count and timing
    task automatic feed(input int n, input int pct, output int acc, output int first, output int last);
        int  guard = 0;
        bit  v, rdy;
        acc = 0; first = 0; last = 0;
        while (acc < n && guard < 20000) begin
            @(negedge clk);
            guard++;
            v = ($urandom_range(99) < 32'(pct));
            s_valid = v;
            s_data = byte_q[acc];
            rdy = s_ready;
            @(posedge clk);
            if (v && rdy) begin
                if (acc == 0) first = guard;
                last = guard;
                acc++;
            end
        end
        @(negedge clk);
        s_valid = 1'b0;
    endtask

    task automatic run(input int kin, input int mode, input int pct, input int skip, input bit hold);
        int keff, nb, acc, first, last, guard, nw;
        keff = (kin < 1 || kin > 4) ? 1 : kin;
        nb = 384 * keff;
        gen_bytes(nb, mode);
        build_model(128 * keff, skip);
        skip_pair = skip;
        clear_monitor();
        @(negedge clk);
        k_num = 3'(kin);
        start = 1'b1;
        @(negedge clk);
        if (!hold) start = 1'b0;
        check("busy_start", 64'(busy), 64'd1);
        check("err_cleared", 64'(mod_err), 64'd0);
        feed(nb, pct, acc, first, last);
        start = 1'b0;
        check("accepts", 64'(acc), 64'(nb));
        if (pct == 100) check("throughput", 64'(last - first), 64'(nb - 1));
        guard = 0;
        while (done_cnt == 0 && guard < 300) begin
            @(posedge clk);
            guard++;
        end
        if (done_cnt == 0) check("done_timeout", 64'd0, 64'd1);
        repeat (20) @(negedge clk);
        check("done_once", 64'(done_cnt), 64'd1);
        check("busy_end", 64'(busy), 64'd0);
        check("s_ready_end", 64'(s_ready), 64'd0);
        check("mod_err", 64'(mod_err), 64'(exp_err));
        check("n_writes", 64'(waddr_q.size()), 64'(exp_q.size()));
        nw = (waddr_q.size() < exp_q.size()) ? waddr_q.size() : exp_q.size();
        for (int i = 0; i < nw; i++) begin
            check("wr_addr", 64'(waddr_q[i]), 64'(i));
            check("wr_data", 64'(wdata_q[i]), 64'(exp_q[i]));
        end
        check("index_seq", 64'(idx_err), 64'd0);
        check("n_readin", 64'(exp_idx), 64'(nb));
        skip_pair = -1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ctl"}, 64'({s_ready, dec_reset, dec_set, dec_readin, busy, done, mod_err, wr_en}), 64'd0);
        check({tag, "_dec"}, 64'({dec_din, dec_in_index}), 64'd0);
        check({tag, "_wr"}, 64'({wr_addr, wr_data}), 64'd0);
    endtask

    initial begin
        int acc, first, last;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        reset = 1'b0;
        repeat (2) @(negedge clk);

        run(1, 0, 100, -1, 1'b0);   // fixed 01 23 45 pattern, continuous
        run(2, 1, 50, -1, 1'b0);    // random in-range, stalling source
        run(1, 2, 70, -1, 1'b0);    // out-of-range pair at index 5
        run(1, 1, 100, -1, 1'b0);   // error clears on next run
        run(4, 1, 90, -1, 1'b0);
        run(5, 1, 100, -1, 1'b0);   // k_num beyond KMAX runs as one poly

        // reset after 100 bytes of a 3-poly run
        gen_bytes(1152, 1);
        clear_monitor();
        @(negedge clk);
        k_num = 3'd3;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        feed(100, 100, acc, first, last);
        reset = 1'b1;
        @(negedge clk);
        check_reset_outputs("mid_reset");
        reset = 1'b0;
        repeat (30) @(negedge clk);
        check("no_done_after_reset", 64'(done_cnt), 64'd0);
        run(3, 1, 80, -1, 1'b0);

        run(0, 1, 100, -1, 1'b1);   // start held high, k_num=0
        run(1, 1, 100, 10, 1'b0);   // decoder drops pair 10

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
